// File: rtl/bus_mem_responder_if.sv
// Tagged request/response bus between an initiator and the memory responder.
interface bus_mem_responder_if #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 13
);
    logic                  reqcyc;
    logic [DATA_WIDTH-1:0] req;
    logic [TAG_WIDTH-1:0]  reqtag;
    logic                  reqack;
    logic                  respcyc;
    logic [DATA_WIDTH-1:0] resp;
    logic [TAG_WIDTH-1:0]  resptag;
    logic                  respack;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );
endinterface

// File: rtl/bus_mem_responder.sv
// Memory-side bus responder: line-read bursts and line-write absorption.
// MEM_RESP_CRITICAL_WORD_FIRST_EN starts reads at the requested word.
module bus_mem_responder #(
    parameter int         BUS_DATA_WIDTH  = 64,
    parameter int         BUS_TAG_WIDTH   = 13,
    parameter int         MEM_DEPTH_WORDS = 4096,
    parameter int         LINE_BEATS      = 8,
    parameter int         READ_LATENCY    = 4,
    parameter logic [3:0] TAG_READ        = 4'h1,
    parameter logic [3:0] TAG_WRITE       = 4'h4
) (
    input  logic              clk,
    input  logic              reset,
    bus_mem_responder_if.slave bus,
    output logic              out_busy
);
    localparam int AW      = $clog2(MEM_DEPTH_WORDS);
    localparam int OW      = $clog2(LINE_BEATS);
    localparam int LW      = $clog2(READ_LATENCY + 1);
    localparam int ADDR_HI = 3 + AW - 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] RD_SEND = 2'd2;
    localparam logic [1:0] WR_DATA = 2'd3;

    logic [1:0]                state;
    logic [AW-OW-1:0]          line;
    logic [OW-1:0]             idx;
    logic [OW-1:0]             beats;
    logic [LW-1:0]             lat;
    logic [BUS_DATA_WIDTH-1:0] mem [MEM_DEPTH_WORDS];

    logic          accept;
    logic          wr_en;
    logic [3:0]    kind;
    logic [OW-1:0] start;
    logic [OW-1:0] idx_next;
    logic          last_beat;

    assign kind      = bus.reqtag[11:8];
    assign accept    = bus.reqcyc && !bus.reqack &&
                       (state == IDLE || state == WR_DATA);
    assign wr_en     = accept && (state == WR_DATA) && !reset;
    assign idx_next  = idx + OW'(1);
    assign last_beat = (beats == OW'(LINE_BEATS - 1));
    assign out_busy  = (state != IDLE);

`ifdef MEM_RESP_CRITICAL_WORD_FIRST_EN
    assign start = bus.req[3 +: OW];
`else
    assign start = '0;
`endif

    // Backing RAM keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{line, beats}] <= bus.req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            line        <= '0;
            idx         <= '0;
            beats       <= '0;
            lat         <= '0;
            bus.reqack  <= 1'b0;
            bus.respcyc <= 1'b0;
            bus.resp    <= '0;
            bus.resptag <= '0;
        end else begin
            bus.reqack <= accept;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        unique case (1'b1)
                            (kind == TAG_READ): begin
                                line        <= bus.req[ADDR_HI -: AW-OW];
                                idx         <= start;
                                beats       <= '0;
                                lat         <= LW'(READ_LATENCY);
                                bus.resptag <= bus.reqtag;
                                state       <= RD_WAIT;
                            end
                            (kind == TAG_WRITE): begin
                                line  <= bus.req[ADDR_HI -: AW-OW];
                                beats <= '0;
                                state <= WR_DATA;
                            end
                            default: ;
                        endcase
                    end
                end
                RD_WAIT: begin
                    lat <= lat - LW'(1);
                    if (lat == LW'(1)) begin
                        bus.respcyc <= 1'b1;
                        bus.resp    <= mem[{line, idx}];
                        state       <= RD_SEND;
                    end
                end
                RD_SEND: begin
                    if (bus.respack) begin
                        if (last_beat) begin
                            bus.respcyc <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            idx      <= idx_next;
                            beats    <= beats + OW'(1);
                            bus.resp <= mem[{line, idx_next}];
                        end
                    end
                end
                WR_DATA: begin
                    if (accept) begin
                        beats <= beats + OW'(1);
                        if (last_beat)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: bursts, stalls, reset, wrap.
module tb_bus_mem_responder;
    localparam int LAT = 4;
`ifdef MEM_RESP_CRITICAL_WORD_FIRST_EN
    localparam int CRIT_START = 3;
`else
    localparam int CRIT_START = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic busy;
    int   total = 0;
    int   bad   = 0;

    bus_mem_responder_if #(.DATA_WIDTH(64), .TAG_WIDTH(13)) bus ();

    bus_mem_responder dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .out_busy (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request beat; n = cycles until reqack seen, 0 on timeout.
    task automatic beat(input logic [63:0] d, input logic [12:0] t,
                        output int n);
        bus.reqcyc = 1'b1;
        bus.req    = d;
        bus.reqtag = t;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus.reqack) begin
                n = i;
                break;
            end
        end
        bus.reqcyc = 1'b0;
    endtask

    task automatic wr_line(input logic [63:0] addr, input logic [63:0] d0);
        int n;
        int acks;
        acks = 0;
        beat(addr, 13'h0400, n);
        if (n > 0) acks++;
        chk("wr_addr_ack", n, 1);
        chk("wr_busy_addr", busy, 1);
        for (int b = 0; b < 8; b++) begin
            beat(d0 + 64'(b), 13'h0400, n);
            if (n > 0) acks++;
            chk("wr_busy_beat", busy, (b == 7) ? 0 : 1);
        end
        chk("wr_acks", acks, 9);
        tick();
    endtask

    task automatic rd_line(input string nm, input logic [63:0] addr,
                           input logic [12:0] tag, input logic [63:0] d0,
                           input int start, input int stall);
        int n;
        int w;
        bus.respack = 1'b1;
        beat(addr, tag, n);
        chk({nm, "_ack_lat"}, n, 1);
        tick();
        w = 1;
        chk({nm, "_ack_pulse"}, bus.reqack, 0);
        while (!bus.respcyc && w < 20) begin
            tick();
            w++;
        end
        chk({nm, "_latency"}, w, LAT);
        for (int b = 0; b < 8; b++) begin
            chk({nm, "_cyc"}, bus.respcyc, 1);
            chk({nm, "_data"}, bus.resp, d0 + 64'((start + b) % 8));
            chk({nm, "_tag"}, bus.resptag, tag);
            if (b == stall) begin
                bus.respack = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk({nm, "_hold"}, bus.resp, d0 + 64'((start + b) % 8));
                end
                bus.respack = 1'b1;
            end
            tick();
        end
        chk({nm, "_end_cyc"}, bus.respcyc, 0);
        chk({nm, "_end_busy"}, busy, 0);
        tick();
    endtask

    initial begin
        int n;
        int w;
        logic seen;
        reset       = 1'b1;
        bus.reqcyc  = 1'b0;
        bus.req     = '0;
        bus.reqtag  = '0;
        bus.respack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_respcyc", bus.respcyc, 0);
        chk("rst_reqack", bus.reqack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp", bus.resp, 0);
        tick();

        wr_line(64'h40, 64'h1008);
        rd_line("rd_basic", 64'h40, 13'h0100, 64'h1008, 0, -1);
        rd_line("rd_stall", 64'h40, 13'h0100, 64'h1008, 0, 2);

        wr_line(64'h80, 64'hA0);
        rd_line("rd_wr", 64'h80, 13'h0100, 64'hA0, 0, -1);

        rd_line("rd_crit", 64'h58, 13'h0100, 64'h1008, CRIT_START, -1);

        beat(64'h40, 13'h0700, n);
        chk("k7_ack", n, 1);
        chk("k7_busy", busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | bus.respcyc | busy | bus.reqack;
        end
        chk("k7_quiet", seen, 0);

        rd_line("rd_wrap", 64'h8040, 13'h0100, 64'h1008, 0, -1);

        bus.respack = 1'b1;
        beat(64'h40, 13'h0100, n);
        w = 0;
        while (!bus.respcyc && w < 20) begin
            tick();
            w++;
        end
        for (int b = 0; b < 3; b++) tick();
        chk("mid_beat3", bus.resp, 64'h100B);
        reset = 1'b1;
        tick();
        chk("mid_respcyc", bus.respcyc, 0);
        chk("mid_reqack", bus.reqack, 0);
        chk("mid_busy", busy, 0);
        reset = 1'b0;
        tick();
        rd_line("rd_after_rst", 64'h40, 13'h0100, 64'h1008, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
